pulse_stretch: RTL and testbench

Pulse-to-level regenerator on the consumer side of the debounced-button one-pulse chain. It accepts single-cycle pulses in the clk_100 domain and turns each one into a held high level of fixed length, followed by a fixed low gap. Pulses that arrive while an output pulse is in progress are queued in a saturating counter and replayed later. It drives LEDs, buzzers and slow peripherals that cannot see a 10 ns pulse.

---
 rtl/pulse_stretch_pkg.sv | 26 ++
 rtl/pulse_stretch.sv | 128 ++++++++++++
 tb/tb_pulse_stretch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_pkg.sv
// ============================================================================
// Module   : pulse_stretch_pkg
// Brief    : Shared state encoding and 100 MHz timing defaults for pulse_stretch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } stretch_state_t;

    // 100 ms high, 50 ms gap at 100 MHz
    localparam int c_HIGH_CYCLES_100M = 10_000_000;
    localparam int c_GAP_CYCLES_100M  = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : pulse_stretch_pkg

`default_nettype wire

// File: rtl/pulse_stretch.sv
// ============================================================================
// Module   : pulse_stretch
// Brief    : Turns single-cycle pulses into fixed-length high levels separated
//            by a fixed low gap, queueing pulses that arrive mid-output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HIGH_CYCLES = c_HIGH_CYCLES_100M,
    parameter int GAP_CYCLES  = c_GAP_CYCLES_100M,
    parameter int PEND_W      = 4
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              ovf_clr,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int                c_CNT_W     = $clog2(max_int(HIGH_CYCLES, GAP_CYCLES) + 1);
    localparam logic [c_CNT_W-1:0] c_HIGH_LOAD = c_CNT_W'(HIGH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  c_PEND_MAX  = '1;

    stretch_state_t      r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_level;
    logic                r_busy;
    logic [PEND_W-1:0]   r_pending;
    logic                r_overflow;

    stretch_state_t      w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_req;
    logic                w_cnt_zero;
    logic                w_replay;
    logic                w_drop;
    logic [PEND_W-1:0]   w_pending_nxt;

    // A pulse in IDLE is consumed by the transition and never queued.
    assign w_req      = pulse_in && (r_state != IDLE);
    assign w_cnt_zero = (r_cnt == '0);
    // A pulse landing in the final gap cycle already counts toward the replay.
    assign w_replay   = (r_state == GAP) && w_cnt_zero && ((r_pending != '0) || w_req);
    assign w_drop     = w_req && !w_replay && (r_pending == c_PEND_MAX);

    always_comb begin
        w_pending_nxt = r_pending;
        case ({w_req, w_replay})
            2'b10:   if (r_pending != c_PEND_MAX) w_pending_nxt = r_pending + 1'b1;
            2'b01:   w_pending_nxt = r_pending - 1'b1;
            default: w_pending_nxt = r_pending;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (pulse_in) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = c_HIGH_LOAD;
                end
            end
            HIGH: begin
                if (w_cnt_zero) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            GAP: begin
                if (w_cnt_zero) begin
                    if (w_replay) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = c_HIGH_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_busy     <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= (w_state_nxt == HIGH);
            r_busy    <= (w_state_nxt != IDLE);
            r_pending <= w_pending_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign level_out = r_level;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule : pulse_stretch

`default_nettype wire

// File: tb/tb_pulse_stretch.sv
// ============================================================================
// Module   : tb_pulse_stretch
// Brief    : Scoreboard bench for pulse_stretch with HIGH=4, GAP=2, PEND_W=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretch;

    localparam int c_H    = 4;
    localparam int c_G    = 2;
    localparam int c_PW   = 2;
    localparam int c_PMAX = 3;

    logic            clk_100 = 1'b0;
    logic            rst;
    logic            pulse_in;
    logic            ovf_clr;
    logic            level_out;
    logic            busy;
    logic [c_PW-1:0] pending;
    logic            overflow;

    pulse_stretch #(
        .HIGH_CYCLES (c_H),
        .GAP_CYCLES  (c_G),
        .PEND_W      (c_PW)
    ) u_dut (
        .clk_100   (clk_100),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .ovf_clr   (ovf_clr),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        int lvl;
        int bsy;
        int pend;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference: 0 idle, 1 high, 2 gap; m_left = cycles left in the phase
    int m_state = 0;
    int m_left  = 0;
    int m_pend  = 0;
    int m_ovf   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_pend  = 0;
        m_ovf   = 0;
    endtask

    task automatic model_edge(input logic p, input logic clr);
        int inc;
        inc = (m_state != 0 && p) ? 1 : 0;
        if (clr) m_ovf = 0;
        case (m_state)
            0: if (p) begin m_state = 1; m_left = c_H; end
            1: begin
                m_left--;
                if (m_left == 0) begin m_state = 2; m_left = c_G; end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pend + inc > 0) begin
                        m_pend  = m_pend + inc - 1;
                        inc     = 0;
                        m_state = 1;
                        m_left  = c_H;
                    end else begin
                        m_state = 0;
                    end
                end
            end
        endcase
        if (inc == 1) begin
            if (m_pend == c_PMAX) m_ovf = 1;
            else                  m_pend++;
        end
    endtask

    task automatic step(input logic p, input logic clr);
        exp_t e;
        pulse_in = p;
        ovf_clr  = clr;
        model_edge(p, clr);
        e.lvl  = (m_state == 1) ? 1 : 0;
        e.bsy  = (m_state != 0) ? 1 : 0;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        sb_q.push_back(e);
        @(posedge clk_100);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("level_out", int'(level_out), e.lvl);
            chk("busy",      int'(busy),      e.bsy);
            chk("pending",   int'(pending),   e.pend);
            chk("overflow",  int'(overflow),  e.ovf);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(posedge clk_100);
        #1;
        chk("rst_level", int'(level_out), 0);
        chk("rst_busy",  int'(busy),      0);
        chk("rst_pend",  int'(pending),   0);
        chk("rst_ovf",   int'(overflow),  0);
        rst = 1'b0;
        model_reset();
        idle(3);

        // single pulse: 4 high, 2 low, then idle
        step(1'b1, 1'b0);
        chk("t1_rise", int'(level_out), 1);
        idle(3);
        chk("t1_last_high", int'(level_out), 1);
        idle(1);
        chk("t1_fall", int'(level_out), 0);
        idle(1);
        chk("t1_gap_busy", int'(busy), 1);
        idle(1);
        chk("t1_busy_fall", int'(busy), 0);
        idle(4);

        // three pulses: one accepted, two queued and replayed
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t2_pend2", int'(pending), 2);
        idle(18);

        // saturation and overflow, then clear
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("t3_sat",  int'(pending),  c_PMAX);
        chk("t3_ovf",  int'(overflow), 1);
        step(1'b0, 1'b1);
        chk("t3_clr",  int'(overflow), 0);
        idle(30);

        // pulse in the final gap cycle with nothing pending
        step(1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0);
        chk("t4_rehigh", int'(level_out), 1);
        chk("t4_busy",   int'(busy),      1);
        chk("t4_pend0",  int'(pending),   0);
        idle(10);

        // held pulse_in: one window plus two queued
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t5_pend2", int'(pending), 2);
        idle(25);

        // asynchronous reset mid-HIGH with requests queued
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("t6_pre_pend", int'(pending), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_level", int'(level_out), 0);
        chk("t6_rst_busy",  int'(busy),      0);
        chk("t6_rst_pend",  int'(pending),   0);
        @(posedge clk_100);
        #1;
        rst = 1'b0;
        model_reset();
        idle(15);
        chk("t6_no_replay", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pulse_stretch

`default_nettype wire
